// File: rtl/ez8_pkg.sv
// Shared definitions for the EZ8 program loader: loader states, sync byte and header field widths.
`default_nettype none

package ez8_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int LEN_HI_W = 4;
  localparam int LEN_W    = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_RST_CPU,
    S_RUN,
    S_ERROR,
    S_CHECKSUM
  } state_t;
endpackage

`default_nettype wire

// File: rtl/ez8_loader.sv
// EZ8 loader: receives a framed program over a byte stream, writes it to instruction memory, then restarts the CPU.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the ERROR path.
`default_nettype none

module ez8_loader
  import ez8_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int RESET_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] instr_writeaddr,
  output logic [15:0]           instr_writedata,
  output logic                  instr_write_en,
  output logic                  cpu_pause,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  state_t              state, state_nxt;
  logic                ready_st;
  logic                accept;
  logic [LEN_HI_W-1:0] len_hi;
  logic [LEN_W-1:0]    len, index, len_now;
  logic [7:0]          hi, lo;
  logic [CNT_W-1:0]    rst_cnt;
  state_t              end_state;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum;
  assign end_state = S_CHECKSUM;
`else
  assign end_state = S_RST_CPU;
`endif

  // Ready is gated by reset so the host sees no acceptance while reset is held.
  assign rx_ready        = ready_st & ~reset;
  assign accept          = rx_valid & rx_ready;
  assign len_now         = {len_hi, rx_data};
  assign instr_writeaddr = ADDR_WIDTH'(index);
  assign instr_writedata = {hi, lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERROR:
        if (accept && rx_data == SYNC_BYTE) state_nxt = S_LEN_HI;
      S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO:  if (accept) state_nxt = (len_now == '0) ? end_state : S_DATA_HI;
      S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
      S_DATA_LO: if (accept) state_nxt = S_WRITE;
      S_WRITE:   state_nxt = (index + LEN_W'(1) == len) ? end_state : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      S_CHECKSUM: if (accept) state_nxt = (rx_data == csum) ? S_RST_CPU : S_ERROR;
`endif
      S_RST_CPU: if (rst_cnt == CNT_W'(RESET_CYCLES - 1)) state_nxt = S_RUN;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_st       = 1'b0;
    instr_write_en = 1'b0;
    cpu_pause      = 1'b1;
    cpu_reset      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      S_IDLE:  ready_st = 1'b1;
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECKSUM: begin
        ready_st = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        instr_write_en = 1'b1;
        busy           = 1'b1;
      end
      S_RST_CPU: begin
        cpu_reset = 1'b1;
        cpu_pause = 1'b0;
        busy      = 1'b1;
      end
      S_RUN: begin
        ready_st  = 1'b1;
        cpu_pause = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: begin
        ready_st = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        error    = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi  <= '0;
      len     <= '0;
      index   <= '0;
      hi      <= '0;
      lo      <= '0;
      rst_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      rst_cnt <= (state == S_RST_CPU) ? rst_cnt + CNT_W'(1) : '0;
      if (accept) begin
        case (state)
          S_LEN_HI:  len_hi <= rx_data[LEN_HI_W-1:0];
          S_LEN_LO: begin
            len   <= len_now;
            index <= '0;
          end
          S_DATA_HI: hi <= rx_data;
          S_DATA_LO: lo <= rx_data;
          default: ;
        endcase
`ifdef LOADER_CHECKSUM_EN
        // Checksum covers the full LEN_HI byte, LEN_LO and every data byte.
        if (state == S_LEN_HI) csum <= rx_data;
        else if (state == S_LEN_LO || state == S_DATA_HI || state == S_DATA_LO)
          csum <= csum ^ rx_data;
`endif
      end
      if (state == S_WRITE) index <= index + LEN_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ez8_loader.sv
// Scoreboard bench for ez8_loader: expected memory writes are queued by the driver and checked by a write monitor.
`default_nettype none

module tb_ez8_loader;
  localparam int AW = 12;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] instr_writeaddr;
  logic [15:0]   instr_writedata;
  logic          instr_write_en;
  logic          cpu_pause, cpu_reset, busy, done, error;

  ez8_loader #(.ADDR_WIDTH(AW), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .instr_writeaddr(instr_writeaddr), .instr_writedata(instr_writedata),
    .instr_write_en(instr_write_en), .cpu_pause(cpu_pause), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int rlen = 0;
  logic [27:0] exp_q[$];
  logic [7:0]  frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && instr_write_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(instr_writeaddr), 32'hFFFF_FFFF);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(instr_writeaddr), 32'(e[27:16]));
        check("write_data", 32'(instr_writedata), 32'(e[15:0]));
      end
    end
  end

  // CPU reset pulse monitor.
  always @(negedge clk) begin
    if (reset) rlen = 0;
    else if (cpu_reset) rlen++;
    else if (rlen > 0) begin
      check("cpu_reset_len", 32'(rlen), 32'(RC));
      pulses++;
      rlen = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gap, input bit add_ck);
    logic [7:0] ck = 8'h00;
    for (int i = 0; i < frame.size(); i++) begin
      if (i > 0) ck = ck ^ frame[i];
      send_byte(frame[i], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    if (add_ck) send_byte(ck, gap);
`else
    if (add_ck) ck = 8'h00;
`endif
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_pause"}, 32'(cpu_pause), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_main();
    frame = '{8'hA5, 8'h00, 8'h05, 8'h40, 8'h50, 8'h01, 8'h01, 8'h41, 8'h00,
              8'h21, 8'h00, 8'h61, 8'h48};
    push_exp(12'd0, 16'h4050);
    push_exp(12'd1, 16'h0101);
    push_exp(12'd2, 16'h4100);
    push_exp(12'd3, 16'h2100);
    push_exp(12'd4, 16'h6148);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_pause", 32'(cpu_pause), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_we", 32'(instr_write_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    #1;
    check("rx_ready_after_release", 32'(rx_ready), 32'd1);
    @(negedge clk);

    // Five-word program, back to back.
    load_main();
    send_byte(frame[0], 0);
    check("busy_after_sync", 32'(busy), 32'd1);
    frame.pop_front();
    frame.push_front(8'hA5);
    for (int i = 1; i < frame.size(); i++) send_byte(frame[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 ^ 8'h05 ^ 8'h40 ^ 8'h50 ^ 8'h01 ^ 8'h01 ^ 8'h41 ^ 8'h00
              ^ 8'h21 ^ 8'h00 ^ 8'h61 ^ 8'h48, 0);
`endif
    exp_pulses++;
    wait_done("main");

    // Zero-length frame.
    frame = '{8'hA5, 8'h00, 8'h00};
    send_frame(0, 1'b1);
    exp_pulses++;
    wait_done("empty");

    // Same program with 3-cycle gaps between bytes.
    load_main();
    send_frame(3, 1'b1);
    exp_pulses++;
    wait_done("gapped");

    // Noise byte while running, then a reload.
    send_byte(8'h33, 1);
    check("noise_done", 32'(done), 32'd1);
    check("noise_pause", 32'(cpu_pause), 32'd0);
    send_byte(8'hA5, 0);
    check("reload_pause", 32'(cpu_pause), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    frame = '{8'h00, 8'h01, 8'h12, 8'h34};
    push_exp(12'd0, 16'h1234);
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h27, 0);
`endif
    exp_pulses++;
    wait_done("reload");

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum lands in ERROR; next sync clears it.
    frame = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    push_exp(12'd0, 16'h1234);
    send_frame(0, 1'b0);
    @(negedge clk);
    check("ck_error", 32'(error), 32'd1);
    check("ck_pause", 32'(cpu_pause), 32'd1);
    check("ck_done", 32'(done), 32'd0);
    send_byte(8'hA5, 0);
    check("ck_error_clear", 32'(error), 32'd0);
    frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    push_exp(12'd0, 16'h1234);
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 0);
    exp_pulses++;
    wait_done("ck_good");
`endif

    // Reset after the second data word, then a fresh load.
    frame = '{8'hA5, 8'h00, 8'h05, 8'h40, 8'h50, 8'h01, 8'h01};
    push_exp(12'd0, 16'h4050);
    push_exp(12'd1, 16'h0101);
    send_frame(0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_pause", 32'(cpu_pause), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    frame = '{8'hA5, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
    push_exp(12'd0, 16'hABCD);
    push_exp(12'd1, 16'h1234);
    send_frame(0, 1'b1);
    exp_pulses++;
    wait_done("fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
